tx_frame_arbiter: RTL
=====================

// Module: tx_frame_arbiter
// PURPOSE
//  Shares the single byte sink (UART TX FIFO write port) between NCH byte-capture channels.
//  Each channel's write/data stream is buffered in a private FIFO.
//  The output is granted to one channel per frame, round-robin; a frame ends with DELIM.
//  Frames are never interleaved on the sink.
// PARAMETERS
//  NCH     2      number of requesting channels (>=2)
//  DEPTH   16     per-channel FIFO depth in bytes (power of two, >=2)
//  DELIM   8'h20  frame-terminating byte (ASCII space)
//  TIMEOUT 255    idle cycles with granted FIFO empty before grant is released (>=1)
// PORTS
//  clk       in   1      system clock
//  rst_n     in   1      reset, asynchronous, active-low
//  en        in   1      clock enable; all state holds and inputs are ignored when 0
//  wr_in     in   NCH    per-channel byte strobe
//  data_in   in   NCH*8  per-channel byte; channel i occupies bits [8i+7:8i]
//  fifo_full in   1      sink full; no byte is issued while 1
//  data_out  out  8      byte to sink, registered
//  write     out  1      sink write strobe, registered, one cycle per byte
//  overflow  out  NCH    sticky per-channel drop flag
//  clr_ovf   in   1      clears all overflow bits (qualified by en)
//  busy      out  1      1 while a channel holds the grant
// BEHAVIOUR
//  Reset (async, rst_n=0): write=0, data_out=0, overflow=0, busy=0.
//   Also on reset: all FIFOs empty, state=IDLE, rr_ptr=0, idle counter=0.
//   Reset mid-frame drops the frame and buffered bytes; write falls immediately.
//  en: every register updates only on clk edges where en=1; wr_in/clr_ovf sampled only then.
//  Push: en & wr_in[i] writes data_in[i] to FIFO i.
//   If FIFO i is full and not popped in the same cycle, the byte is dropped and overflow[i]<=1.
//   Push to a full FIFO that is popped in the same cycle is accepted; no overflow.
//   Pointers are $clog2(DEPTH)+1 bits with natural wrap; full/empty come from the MSB compare.
//  overflow: clr_ovf clears all bits; a new drop in the same cycle as clr_ovf wins (bit set).
//  FSM states IDLE, GRANT; busy = (state==GRANT).
//   IDLE: if any FIFO is non-empty, pick the first non-empty channel scanning from rr_ptr upward (mod NCH).
//    On a pick: gnt<=that channel, rr_ptr<=(gnt+1)%NCH, idle counter<=0, ->GRANT. No pop in this cycle.
//   GRANT: if !fifo_full & !empty[gnt], pop FIFO gnt; data_out<=head, write<=1, idle counter<=0.
//    If the popped byte == DELIM, ->IDLE.
//    If empty[gnt] & !fifo_full, idle counter+1; reaching TIMEOUT releases the grant (->IDLE, write=0).
//    If fifo_full: no pop, write<=0, idle counter holds.
//   write<=0 on any edge without a pop.
//  Latency: wr_in sampled at edge 0 into an empty, idle arbiter -> write=1 with that byte after edge 2.
//  Throughput: one byte per enabled cycle within a frame (write may stay high back-to-back).
//  After DELIM, the next frame's first byte issues no earlier than 2 edges later (IDLE pick + pop).
//  Data ordering within a channel is preserved exactly; bytes of two channels never interleave within a frame.
// TESTING
//  1 Single frame: ch0 pushes 31,32,20 on consecutive edges, fifo_full=0.
//    -> write pulses carry 31,32,20 in order; first write after edge 2; busy falls after 20.
//  2 Contention: after reset, ch0 pushes 31,20 and ch1 pushes 39,20 on the same edges.
//    -> sink sees 31,20,39,20; no interleave; rr_ptr returns to 0.
//  3 Backpressure: fifo_full=1 for 5 cycles mid-frame of 31,32,33,20.
//    -> write=0 throughout the stall; no byte lost or duplicated; sequence resumes when fifo_full falls.
//  4 Overflow: fifo_full=1, ch1 pushes 17 bytes 00..10.
//    -> overflow[1]=1, overflow[0]=0; after release 00..0F delivered and 10 lost.
//    -> clr_ovf pulse clears the flag; clr_ovf coincident with a new drop leaves it set.
//  5 Timeout: TIMEOUT=4; ch0 pushes only 31; ch1 pushes 39,20.
//    -> 31 written, then 4 idle cycles, grant moves to ch1, 39,20 written.
//  6 Enable/reset: en=0 for 3 cycles mid-frame -> outputs frozen and wr_in ignored.
//    -> rst_n pulsed low mid-frame: write=0 and busy=0 at once; no further writes after release.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// ============================================================================
//  Module      : tx_frame_arbiter
//  Description : Round-robin, frame-granular arbiter that shares one byte sink
//                (UART TX FIFO write port) between NCH buffered capture
//                channels. A grant lasts until DELIM is issued or the granted
//                FIFO stays empty for TIMEOUT sink-ready cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_frame_arbiter #(
    parameter int         NCH     = 2,
    parameter int         DEPTH   = 16,
    parameter logic [7:0] DELIM   = 8'h20,
    parameter int         TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NCH-1:0]     wr_in,
    input  logic [NCH*8-1:0]   data_in,
    input  logic               fifo_full,
    output logic [7:0]         data_out,
    output logic               write,
    output logic [NCH-1:0]     overflow,
    input  logic               clr_ovf,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   gnt;
    logic [CW-1:0]   rr_ptr;
    logic [TW-1:0]   idle_cnt;

    logic [NCH-1:0]  empty;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  pop;
    logic [NCH-1:0]  drop;
    logic [7:0]      head [NCH];

    logic            pick_valid;
    logic [CW-1:0]   pick_idx;
    logic [CW-1:0]   rr_next;
    logic            gnt_empty;
    logic [7:0]      gnt_head;

    // ------------------------------------------------------------------------
    // Per-channel byte FIFOs. Pointers carry one extra wrap bit so that full
    // and empty are distinguished by the MSB alone.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_fifo
            logic [7:0]    mem [DEPTH];
            logic [PW-1:0] wptr;
            logic [PW-1:0] rptr;
            logic          push_ok;

            assign empty[i] = (wptr == rptr);
            assign full[i]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
            assign pop[i]   = en && (state == GRANT) && (gnt == CW'(i)) && !fifo_full && !empty[i];
            // A full FIFO still accepts a byte when the head leaves in the same cycle.
            assign push_ok  = en && wr_in[i] && (!full[i] || pop[i]);
            assign drop[i]  = en && wr_in[i] && full[i] && !pop[i];
            assign head[i]  = mem[rptr[AW-1:0]];

            // Storage array: written on accepted pushes, no reset needed.
            always_ff @(posedge clk) begin
                if (push_ok) begin
                    mem[wptr[AW-1:0]] <= data_in[8*i +: 8];
                end
            end

            // Read/write pointers advance on accepted push and pop.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wptr <= '0;
                    rptr <= '0;
                end else begin
                    if (push_ok) begin
                        wptr <= wptr + 1'b1;
                    end
                    if (pop[i]) begin
                        rptr <= rptr + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Sticky drop flags; a drop in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= '0;
        end else if (en) begin
            overflow <= (clr_ovf ? '0 : overflow) | drop;
        end
    end

    // Round-robin pick: first non-empty channel scanning upward from rr_ptr.
    // The loop runs from the far end back so the nearest candidate wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            automatic int idx = int'(rr_ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!empty[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = CW'(idx);
            end
        end
        rr_next = (int'(pick_idx) == NCH - 1) ? '0 : pick_idx + 1'b1;
    end

    assign gnt_empty = empty[gnt];
    assign gnt_head  = head[gnt];
    assign busy      = (state == GRANT);

    // Grant FSM with registered sink outputs; write is a one-cycle strobe per pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
            write    <= 1'b0;
            data_out <= 8'h00;
        end else if (en) begin
            write <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt      <= pick_idx;
                        rr_ptr   <= rr_next;
                        idle_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // Sink full: hold everything, including the idle count.
                    if (!fifo_full) begin
                        if (!gnt_empty) begin
                            data_out <= gnt_head;
                            write    <= 1'b1;
                            idle_cnt <= '0;
                            if (gnt_head == DELIM) begin
                                state <= IDLE;
                            end
                        end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                            idle_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
